emc_ext_mem_if: RTL and testbench
=================================

Name: emc_ext_mem_if

Overview:
External bus interface for the EMC08 core. It converts single-beat core requests (code fetch, data read, data write) into a multiplexed pin-level bus cycle. P0 carries the low address byte, then data. P2 carries the high address byte. ALE latches the address, and PSEN_B / RD_B / WR_B strobe the access. The block sits between the core's fetch/MOVX unit and the P0/P2/P3/PSEN_B pad cells, and runs on the core clock.

Parameters:
ADDR_W, 16, request address width (upper 8 bits drive P2, lower 8 bits drive P0).
WAIT_STATES, 1, extra strobe cycles before read sampling / write release (0..15).

Ports:
CLOCK  input  1  core clock; all state changes on rising edge.
RESET_B  input  1  asynchronous active-low reset.
req_valid  input  1  core request present.
req_ready  output  1  block can accept a request (IDLE only).
req_code  input  1  1 = code fetch (PSEN_B), 0 = data access (RD_B/WR_B).
req_wr  input  1  1 = write (valid only when req_code=0).
req_addr  input  ADDR_W  access address.
req_wdata  input  8  write data.
rsp_valid  output  1  one-cycle pulse; transaction complete.
rsp_rdata  output  8  read data; valid with rsp_valid, held until next read completes.
p0_out  output  8  P0 pad output value.
p0_oe  output  1  P0 pad output enable (1 = drive).
p0_in  input  8  P0 pad input value.
p2_out  output  8  P2 pad value (high address).
ale  output  1  address latch enable, active high.
psen_b  output  1  program store enable, active low.
rd_b  output  1  data read strobe, active low (P3.7 function).
wr_b  output  1  data write strobe, active low (P3.6 function).
busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, RESET_B=0):
  - State = IDLE.
  - psen_b = rd_b = wr_b = 1.
  - ale = 0, p0_oe = 0, p0_out = 0x00, p2_out = 0xFF.
  - rsp_valid = 0, rsp_rdata = 0x00, wait counter = 0.
  - Reset mid-transaction aborts the transaction with no rsp_valid pulse; strobes release immediately (asynchronously).
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted on a rising edge with req_valid & req_ready.
  - addr, code, wr and wdata are captured into internal registers; inputs are don't-care afterwards.
  - req_valid held while busy is ignored, not queued.
- FSM:
  - IDLE: all strobes inactive, p0_oe = 0. Accept → ADDR.
  - ADDR (1 cycle): p0_out = addr[7:0], p0_oe = 1, p2_out = addr[15:8], ale = 1. → HOLD.
  - HOLD (1 cycle): ale = 0, P0/P2 held (address hold after ALE falls). → STROBE. Wait counter loaded with WAIT_STATES.
  - STROBE (WAIT_STATES+1 cycles), by access type:
    - Code read: p0_oe = 0, psen_b = 0.
    - Data read: p0_oe = 0, rd_b = 0.
    - Write: p0_out = wdata, p0_oe = 1, wr_b = 0.
    - Counter decrements each cycle. On the cycle the counter is 0, a read registers p0_in into rsp_rdata at that edge. → END.
  - END (1 cycle): all strobes = 1; for writes P0 is still driven with wdata (data hold), for reads p0_oe = 0. rsp_valid = 1. → IDLE.
- Latency:
  - Acceptance edge = cycle 0; rsp_valid is high in cycle WAIT_STATES+4.
  - Throughput is one transaction per WAIT_STATES+5 cycles.
- Pin rules:
  - p2_out keeps the last address high byte after completion (not returned to 0xFF).
  - Exactly one of psen_b/rd_b/wr_b may be low at any time.
  - ale is never high while any strobe is low.
  - p0_oe is never 1 while psen_b or rd_b is low.
- Writes: rsp_rdata is unchanged.
- Illegal req_code=1 & req_wr=1: treated as a code read.

Test Plan:
- Reset: assert RESET_B=0 during STROBE of a write → psen_b=rd_b=wr_b=1, p0_oe=0, p2_out=0xFF, rsp_valid=0 immediately; after release, req_ready=1.
- Code fetch at addr 0x12A5, WAIT_STATES=1, p0_in=0x3C during strobe → ale high 1 cycle with p0_out=0xA5, p2_out=0x12; psen_b low 2 cycles; rsp_valid in cycle 5 with rsp_rdata=0x3C.
- Data write at addr 0x0040, wdata=0x5A → wr_b low 2 cycles with p0_out=0x5A, p0_oe=1; rd_b/psen_b stay 1; rsp_valid in cycle 5; rsp_rdata unchanged.
- Data read at addr 0xFFFF, WAIT_STATES=0, p0_in=0x81 → rd_b low exactly 1 cycle; rsp_valid in cycle 4 with rsp_rdata=0x81; p2_out stays 0xFF afterwards.
- Back-to-back: req_valid held high for 3 requests → each accepted only in IDLE; 3 rsp_valid pulses spaced WAIT_STATES+5 cycles; no request dropped or duplicated.
- Bus-contention checker over random traffic: never p0_oe=1 with psen_b=0 or rd_b=0; never two strobes low; never ale=1 with any strobe low.

Source files
------------

// File: rtl/emc_ext_mem_if_if.sv
// Core-side request/response bundle for the EMC08 external memory interface.
// The core's fetch/MOVX unit is the master; emc_ext_mem_if is the slave.
interface emc_ext_mem_if_if #(
  parameter int unsigned ADDR_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_code;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;

  modport master (
    output req_valid, req_code, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_code, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/emc_ext_mem_if.sv
// EMC08 external bus interface: turns single-beat core requests into a
// multiplexed P0/P2 bus cycle with ALE and PSEN_B/RD_B/WR_B strobes.
// All pin outputs come straight from flops so reset releases them at once.
module emc_ext_mem_if #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            CLOCK,
  input  logic            RESET_B,
  emc_ext_mem_if_if.slave bus,
  output logic [7:0]      p0_out,
  output logic            p0_oe,
  input  logic [7:0]      p0_in,
  output logic [7:0]      p2_out,
  output logic            ale,
  output logic            psen_b,
  output logic            rd_b,
  output logic            wr_b,
  output logic            busy
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StHold,
    StStrobe,
    StEnd
  } state_e;

  state_e     state_q;
  logic       code_q;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic [3:0] wait_q;

  logic [7:0] p0_out_q;
  logic       p0_oe_q;
  logic [7:0] p2_out_q;
  logic       ale_q;
  logic       psen_b_q;
  logic       rd_b_q;
  logic       wr_b_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;

  // Bus-cycle sequencer; every output is registered alongside the state.
  always_ff @(posedge CLOCK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q     <= StIdle;
      code_q      <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= 8'h00;
      wait_q      <= 4'd0;
      p0_out_q    <= 8'h00;
      p0_oe_q     <= 1'b0;
      p2_out_q    <= 8'hFF;
      ale_q       <= 1'b0;
      psen_b_q    <= 1'b1;
      rd_b_q      <= 1'b1;
      wr_b_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            code_q   <= bus.req_code;
            // A code fetch flagged as a write is still just a code fetch.
            wr_q     <= bus.req_wr & ~bus.req_code;
            wdata_q  <= bus.req_wdata;
            p0_out_q <= bus.req_addr[7:0];
            p0_oe_q  <= 1'b1;
            p2_out_q <= bus.req_addr[ADDR_W-1 -: 8];
            ale_q    <= 1'b1;
            state_q  <= StAddr;
          end
        end
        StAddr: begin
          // Address stays on P0/P2 for one more cycle after ALE falls.
          ale_q   <= 1'b0;
          state_q <= StHold;
        end
        StHold: begin
          wait_q  <= WaitLoad;
          state_q <= StStrobe;
          if (wr_q) begin
            p0_out_q <= wdata_q;
            p0_oe_q  <= 1'b1;
            wr_b_q   <= 1'b0;
          end else begin
            // P0 turns around on the same edge the read strobe asserts.
            p0_oe_q <= 1'b0;
            if (code_q) begin
              psen_b_q <= 1'b0;
            end else begin
              rd_b_q <= 1'b0;
            end
          end
        end
        StStrobe: begin
          if (wait_q == 4'd0) begin
            if (!wr_q) begin
              rsp_rdata_q <= p0_in;
            end
            psen_b_q    <= 1'b1;
            rd_b_q      <= 1'b1;
            wr_b_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StEnd;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StEnd: begin
          // Write data was held through this cycle; release P0 now.
          p0_oe_q <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Pin and handshake outputs.
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_rdata = rsp_rdata_q;
    busy          = (state_q != StIdle);
    p0_out        = p0_out_q;
    p0_oe         = p0_oe_q;
    p2_out        = p2_out_q;
    ale           = ale_q;
    psen_b        = psen_b_q;
    rd_b          = rd_b_q;
    wr_b          = wr_b_q;
  end

endmodule

// File: tb/tb_emc_ext_mem_if.sv
// Self-checking bench for emc_ext_mem_if: one instance with one wait state
// (table vectors, random traffic, back-to-back, mid-cycle reset) and one with
// zero wait states (single data read).
module tb_emc_ext_mem_if;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- DUT A: WAIT_STATES = 1 ----------------
  emc_ext_mem_if_if #(.ADDR_W(16)) a_bus ();
  logic [7:0] a_p0_out, a_p0_in, a_p2_out;
  logic       a_p0_oe, a_ale, a_psen_b, a_rd_b, a_wr_b, a_busy;

  emc_ext_mem_if #(.ADDR_W(16), .WAIT_STATES(1)) dut_a (
    .CLOCK(clk), .RESET_B(rst_n), .bus(a_bus),
    .p0_out(a_p0_out), .p0_oe(a_p0_oe), .p0_in(a_p0_in), .p2_out(a_p2_out),
    .ale(a_ale), .psen_b(a_psen_b), .rd_b(a_rd_b), .wr_b(a_wr_b), .busy(a_busy)
  );

  // ---------------- DUT B: WAIT_STATES = 0 ----------------
  emc_ext_mem_if_if #(.ADDR_W(16)) b_bus ();
  logic [7:0] b_p0_out, b_p0_in, b_p2_out;
  logic       b_p0_oe, b_ale, b_psen_b, b_rd_b, b_wr_b, b_busy;

  emc_ext_mem_if #(.ADDR_W(16), .WAIT_STATES(0)) dut_b (
    .CLOCK(clk), .RESET_B(rst_n), .bus(b_bus),
    .p0_out(b_p0_out), .p0_oe(b_p0_oe), .p0_in(b_p0_in), .p2_out(b_p2_out),
    .ale(b_ale), .psen_b(b_psen_b), .rd_b(b_rd_b), .wr_b(b_wr_b), .busy(b_busy)
  );

  // Pin-level bus rules, checked every cycle out of reset on both instances.
  function automatic int bus_ok(logic psen, logic rd, logic wr, logic al, logic oe);
    int low = 0;
    low = int'(!psen) + int'(!rd) + int'(!wr);
    if (low > 1) return 0;
    if (al && low != 0) return 0;
    if (oe && (!psen || !rd)) return 0;
    return 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("bus_rules_a", bus_ok(a_psen_b, a_rd_b, a_wr_b, a_ale, a_p0_oe), 1);
      check("bus_rules_b", bus_ok(b_psen_b, b_rd_b, b_wr_b, b_ale, b_p0_oe), 1);
    end
  end

  // Measurements from one transaction on DUT A.
  int         m_rsp_cyc, m_rsp_cnt, m_psen, m_rd, m_wr, m_ale, m_wdata_bad;
  logic [7:0] m_rdata, m_ale_p0, m_ale_p2, m_p2_after;
  logic       m_ale_oe;

  // Issue one request on DUT A; memory drives pin on P0 while a read strobe is low.
  task automatic run_txn(input logic code, input logic wr, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] pin);
    @(negedge clk);
    check("ready_before_req", a_bus.req_ready, 1);
    a_bus.req_valid = 1'b1;
    a_bus.req_code  = code;
    a_bus.req_wr    = wr;
    a_bus.req_addr  = addr;
    a_bus.req_wdata = wdata;
    a_p0_in         = ~pin;
    m_rsp_cyc = -1; m_rsp_cnt = 0; m_psen = 0; m_rd = 0; m_wr = 0; m_ale = 0;
    m_wdata_bad = 0; m_rdata = 8'h00; m_ale_p0 = 8'h00; m_ale_p2 = 8'h00; m_ale_oe = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Inputs are don't-care after acceptance; scramble them.
        a_bus.req_valid = 1'b0;
        a_bus.req_addr  = ~addr;
        a_bus.req_wdata = ~wdata;
        a_bus.req_code  = ~code;
        a_bus.req_wr    = ~wr;
      end
      if (!a_psen_b) m_psen++;
      if (!a_rd_b) m_rd++;
      if (!a_wr_b) m_wr++;
      if (a_ale) begin
        m_ale++;
        m_ale_p0 = a_p0_out;
        m_ale_p2 = a_p2_out;
        m_ale_oe = a_p0_oe;
      end
      if (!a_wr_b && (a_p0_out != wdata || !a_p0_oe)) m_wdata_bad++;
      if (a_bus.rsp_valid) begin
        m_rsp_cnt++;
        if (m_rsp_cyc < 0) begin
          m_rsp_cyc = c;
          m_rdata   = a_bus.rsp_rdata;
        end
      end
      a_p0_in = (!a_psen_b || !a_rd_b) ? pin : ~pin;
      if (m_rsp_cyc >= 0 && c > m_rsp_cyc) break;
    end
    m_p2_after = a_p2_out;
  endtask

  typedef struct {
    logic       code;
    logic       wr;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] pin;
    logic [7:0] exp_rdata;
    int         exp_psen;
    int         exp_rd;
    int         exp_wr;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] exp_rd_model;
    logic [7:0] pins[3];
    logic [15:0] addrs[3];
    int acc, nrsp, ale_cnt, wait_cnt;
    int rcyc[3];
    logic [7:0] cur_pin;
    logic rc, rw;
    logic [15:0] ra;
    logic [7:0] rwd, rpin;

    // code, wr, addr, wdata, p0_in, rdata, psen-low, rd-low, wr-low cycles
    vecs[0] = '{1'b1, 1'b0, 16'h12A5, 8'h00, 8'h3C, 8'h3C, 2, 0, 0};
    vecs[1] = '{1'b0, 1'b1, 16'h0040, 8'h5A, 8'h77, 8'h3C, 0, 0, 2};
    vecs[2] = '{1'b0, 1'b0, 16'h8001, 8'h00, 8'hC3, 8'hC3, 0, 2, 0};
    vecs[3] = '{1'b1, 1'b1, 16'h0102, 8'h99, 8'h4E, 8'h4E, 2, 0, 0};
    vecs[4] = '{1'b0, 1'b1, 16'hBEEF, 8'hA5, 8'h12, 8'h4E, 0, 0, 2};

    a_bus.req_valid = 1'b0; a_bus.req_code = 1'b0; a_bus.req_wr = 1'b0;
    a_bus.req_addr = 16'h0; a_bus.req_wdata = 8'h0; a_p0_in = 8'h0;
    b_bus.req_valid = 1'b0; b_bus.req_code = 1'b0; b_bus.req_wr = 1'b0;
    b_bus.req_addr = 16'h0; b_bus.req_wdata = 8'h0; b_p0_in = 8'h0;

    // ---- Reset state ----
    repeat (3) @(negedge clk);
    check("rst_psen_b", a_psen_b, 1);
    check("rst_rd_b", a_rd_b, 1);
    check("rst_wr_b", a_wr_b, 1);
    check("rst_ale", a_ale, 0);
    check("rst_p0_oe", a_p0_oe, 0);
    check("rst_p0_out", a_p0_out, 8'h00);
    check("rst_p2_out", a_p2_out, 8'hFF);
    check("rst_rsp_valid", a_bus.rsp_valid, 0);
    check("rst_rsp_rdata", a_bus.rsp_rdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", a_bus.req_ready, 1);
    check("rst_busy", a_busy, 0);

    // ---- Table-driven transactions, WAIT_STATES=1 ----
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].code, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].pin);
      check($sformatf("v%0d_rsp_cycle", i), m_rsp_cyc, 5);
      check($sformatf("v%0d_rsp_count", i), m_rsp_cnt, 1);
      check($sformatf("v%0d_rdata", i), m_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_psen_low", i), m_psen, vecs[i].exp_psen);
      check($sformatf("v%0d_rd_low", i), m_rd, vecs[i].exp_rd);
      check($sformatf("v%0d_wr_low", i), m_wr, vecs[i].exp_wr);
      check($sformatf("v%0d_ale_cycles", i), m_ale, 1);
      check($sformatf("v%0d_ale_p0", i), m_ale_p0, vecs[i].addr[7:0]);
      check($sformatf("v%0d_ale_p2", i), m_ale_p2, vecs[i].addr[15:8]);
      check($sformatf("v%0d_ale_oe", i), m_ale_oe, 1);
      check($sformatf("v%0d_wdata_on_p0", i), m_wdata_bad, 0);
      check($sformatf("v%0d_p2_after", i), m_p2_after, vecs[i].addr[15:8]);
    end

    // ---- Random traffic with a read-data model ----
    exp_rd_model = 8'h4E;
    for (int i = 0; i < 16; i++) begin
      rc   = 1'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      ra   = 16'($urandom);
      rwd  = 8'($urandom);
      rpin = 8'($urandom);
      run_txn(rc, rw, ra, rwd, rpin);
      if (rc || !rw) exp_rd_model = rpin;
      check($sformatf("rnd%0d_rdata", i), m_rdata, exp_rd_model);
      check($sformatf("rnd%0d_rsp_cycle", i), m_rsp_cyc, 5);
      check($sformatf("rnd%0d_wdata_on_p0", i), m_wdata_bad, 0);
    end

    // ---- Back-to-back: req_valid held for three code fetches ----
    pins  = '{8'h11, 8'h22, 8'h33};
    addrs = '{16'h2000, 16'h2001, 16'h2002};
    acc = 0; nrsp = 0; ale_cnt = 0; cur_pin = 8'h00;
    rcyc = '{-1, -1, -1};
    @(negedge clk);
    a_bus.req_valid = 1'b1;
    a_bus.req_code  = 1'b1;
    a_bus.req_wr    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) @(negedge clk);
      if (acc == 3) a_bus.req_valid = 1'b0;
      if (a_bus.rsp_valid) begin
        if (nrsp < 3) begin
          rcyc[nrsp] = c;
          check($sformatf("b2b_rdata%0d", nrsp), a_bus.rsp_rdata, pins[nrsp]);
        end
        nrsp++;
      end
      if (a_ale) begin
        if (ale_cnt < 3) check($sformatf("b2b_addr%0d", ale_cnt), a_p0_out, addrs[ale_cnt][7:0]);
        ale_cnt++;
      end
      if (a_bus.req_valid && a_bus.req_ready && acc < 3) begin
        a_bus.req_addr = addrs[acc];
        cur_pin = pins[acc];
        acc++;
      end
      a_p0_in = (!a_psen_b || !a_rd_b) ? cur_pin : ~cur_pin;
    end
    check("b2b_accepted", acc, 3);
    check("b2b_rsp_count", nrsp, 3);
    check("b2b_ale_count", ale_cnt, 3);
    check("b2b_spacing01", rcyc[1] - rcyc[0], 6);
    check("b2b_spacing12", rcyc[2] - rcyc[1], 6);

    // ---- WAIT_STATES=0 data read at 0xFFFF ----
    @(negedge clk);
    b_bus.req_valid = 1'b1;
    b_bus.req_code  = 1'b0;
    b_bus.req_wr    = 1'b0;
    b_bus.req_addr  = 16'hFFFF;
    b_p0_in         = 8'h7E;
    m_rsp_cyc = -1; m_rd = 0; m_rdata = 8'h00; m_ale_p0 = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) b_bus.req_valid = 1'b0;
      if (!b_rd_b) m_rd++;
      if (b_ale) m_ale_p0 = b_p0_out;
      if (b_bus.rsp_valid && m_rsp_cyc < 0) begin
        m_rsp_cyc = c;
        m_rdata   = b_bus.rsp_rdata;
      end
      b_p0_in = !b_rd_b ? 8'h81 : 8'h7E;
    end
    check("ws0_rd_low", m_rd, 1);
    check("ws0_rsp_cycle", m_rsp_cyc, 4);
    check("ws0_rdata", m_rdata, 8'h81);
    check("ws0_ale_p0", m_ale_p0, 8'hFF);
    check("ws0_p2_after", b_p2_out, 8'hFF);
    check("ws0_ready_after", b_bus.req_ready, 1);

    // ---- Reset during the strobe of a write ----
    @(negedge clk);
    a_bus.req_valid = 1'b1;
    a_bus.req_code  = 1'b0;
    a_bus.req_wr    = 1'b1;
    a_bus.req_addr  = 16'h3456;
    a_bus.req_wdata = 8'hC7;
    wait_cnt = 0;
    do begin
      @(negedge clk);
      a_bus.req_valid = 1'b0;
      wait_cnt++;
    end while (a_wr_b && wait_cnt < 10);
    check("mid_rst_saw_wr_strobe", a_wr_b, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_psen_b", a_psen_b, 1);
    check("mid_rst_rd_b", a_rd_b, 1);
    check("mid_rst_wr_b", a_wr_b, 1);
    check("mid_rst_p0_oe", a_p0_oe, 0);
    check("mid_rst_p2_out", a_p2_out, 8'hFF);
    check("mid_rst_rsp_valid", a_bus.rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) check("mid_rst_ready_after", a_bus.req_ready, 1);
      if (a_bus.rsp_valid) nrsp++;
    end
    check("mid_rst_no_rsp", nrsp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
